pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/next_pc_calc.sv | 34 +++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding, reset PC and control-flow bundle
// for the fetch/execute PC sequencer.
package cpu_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_EXEC  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic branch;
    logic branch_ne;
    logic branch_gz;
    logic jump;
    logic alu_zero;
    logic alu_positive;
  } cf_t;

  function automatic logic [31:0] word_inc(input logic [31:0] a);
    return a + 32'd1;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational branch/jump target selection.
// Jump wins over a taken branch; all adds wrap modulo 2^32.
module next_pc_calc
  import cpu_ctrl_pkg::*;
(
  input  cf_t         i_cf,
  input  logic [31:0] i_post_pc,
  input  logic [31:0] i_sext_immed,
  input  logic [25:0] i_jump_addr,
  output logic [31:0] o_next_pc
);

  logic        w_taken;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_br_tgt;

  assign w_taken =
      (i_cf.branch    &  i_cf.alu_zero)
    | (i_cf.branch_ne & ~i_cf.alu_zero)
    | (i_cf.branch_gz &  i_cf.alu_positive);

  assign w_jump_tgt = {i_post_pc[31:26], i_jump_addr};
  assign w_br_tgt   = i_post_pc + i_sext_immed;

  always_comb begin
    o_next_pc = i_post_pc;
    priority case (1'b1)
      i_cf.jump: o_next_pc = w_jump_tgt;
      w_taken:   o_next_pc = w_br_tgt;
      default:   o_next_pc = i_post_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/hold/execute sequencing of the program counter,
// instruction capture and retired-instruction counting.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               resolve_valid,
  input  logic               branch,
  input  logic               branch_ne,
  input  logic               branch_gz,
  input  logic               jump,
  input  logic               alu_zero,
  input  logic               alu_positive,
  input  logic [31:0]        sext_immed,
  input  logic [25:0]        jump_addr,
  output logic [31:0]        pc,
  output logic [31:0]        post_pc,
  output logic [31:0]        retired_count
);

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_post_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;

  cf_t         w_cf;
  logic [31:0] w_next_pc;
  logic        w_fetch_done;
  logic        w_exec_done;

  assign w_cf = '{
    branch:       branch,
    branch_ne:    branch_ne,
    branch_gz:    branch_gz,
    jump:         jump,
    alu_zero:     alu_zero,
    alu_positive: alu_positive
  };

  next_pc_calc u_next_pc (
    .i_cf         (w_cf),
    .i_post_pc    (r_post_pc),
    .i_sext_immed (sext_immed),
    .i_jump_addr  (jump_addr),
    .o_next_pc    (w_next_pc)
  );

  // Handshakes only count in their own state; strays elsewhere are dropped.
  assign w_fetch_done = (r_state == ST_FETCH) & imem_ack;
  assign w_exec_done  = (r_state == ST_EXEC) & resolve_valid;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack)      w_state_nxt = ST_HOLD;
      ST_HOLD:  if (instr_ready)   w_state_nxt = ST_EXEC;
      ST_EXEC:  if (resolve_valid) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_post_pc <= word_inc(RESET_PC);
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fetch_done) begin
        r_instr   <= imem_rdata;
        r_post_pc <= word_inc(r_pc);
      end
      // post_pc tracks pc+1 from the moment pc moves.
      if (w_exec_done) begin
        r_pc      <= w_next_pc;
        r_post_pc <= word_inc(w_next_pc);
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign imem_req      = (r_state == ST_FETCH);
  assign imem_addr     = IMEM_AW'(r_pc);
  assign instr_valid   = (r_state == ST_HOLD);
  assign instr         = r_instr;
  assign pc            = r_pc;
  assign post_pc       = r_post_pc;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer
// against a transaction-level model of fetch/hold/execute.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        resolve_valid;
  logic        branch, branch_ne, branch_gz, jump;
  logic        alu_zero, alu_positive;
  logic [31:0] sext_immed;
  logic [25:0] jump_addr;
  logic [31:0] pc, post_pc, retired_count;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0), .IMEM_AW(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .resolve_valid(resolve_valid),
    .branch(branch), .branch_ne(branch_ne), .branch_gz(branch_gz),
    .jump(jump), .alu_zero(alu_zero), .alu_positive(alu_positive),
    .sext_immed(sext_immed), .jump_addr(jump_addr),
    .pc(pc), .post_pc(post_pc), .retired_count(retired_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 waits after reset, 1 awaits memory, 2 offers the
  // instruction, 3 awaits resolution.
  bit          live = 1'b0;
  int          m_ph;
  logic [31:0] m_pc, m_instr, m_cnt;

  function automatic logic [31:0] ref_target(input logic [31:0] cur);
    logic [31:0] seq;
    logic        tk;
    seq = cur + 32'd1;
    tk = (branch && alu_zero) || (branch_ne && !alu_zero)
      || (branch_gz && alu_positive);
    if (jump) return {seq[31:26], jump_addr};
    if (tk) return seq + sext_immed;
    return seq;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live = 1'b1;
      m_ph = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
    end else if (live) begin
      if (m_ph == 0) m_ph = 1;
      else if (m_ph == 1 && imem_ack) begin
        m_instr = imem_rdata; m_ph = 2;
      end else if (m_ph == 2 && instr_ready) m_ph = 3;
      else if (m_ph == 3 && resolve_valid) begin
        m_pc = ref_target(m_pc); m_cnt = m_cnt + 32'd1; m_ph = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("imem_req", 32'(imem_req), 32'(m_ph == 1));
      chk("instr_valid", 32'(instr_valid), 32'(m_ph == 2));
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("post_pc", post_pc, m_pc + 32'd1);
      chk("instr", instr, m_instr);
      chk("retired", retired_count, m_cnt);
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_ph(input int ph);
    int n = 0;
    while (m_ph != ph && n < 50) begin
      tick; n++;
    end
    chk("wait_phase", 32'(m_ph), 32'(ph));
  endtask

  task automatic do_fetch(input logic [31:0] d, input int dly);
    wait_ph(1);
    repeat (dly) tick;
    imem_ack = 1'b1; imem_rdata = d;
    tick;
    imem_ack = 1'b0;
  endtask

  task automatic do_accept(input int dly);
    wait_ph(2);
    repeat (dly) tick;
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
  endtask

  task automatic do_resolve(input logic j, input logic b, input logic z,
                            input logic [31:0] imm, input logic [25:0] ja);
    wait_ph(3);
    jump = j; branch = b; alu_zero = z;
    sext_immed = imm; jump_addr = ja;
    resolve_valid = 1'b1;
    tick;
    resolve_valid = 1'b0;
    jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
  endtask

  task automatic step(input logic j, input logic b, input logic z,
                      input logic [31:0] imm, input logic [25:0] ja);
    do_fetch($urandom, 0);
    do_accept(0);
    do_resolve(j, b, z, imm, ja);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    resolve_valid = 1'b0; branch = 1'b0; branch_ne = 1'b0;
    branch_gz = 1'b0; jump = 1'b0; alu_zero = 1'b0; alu_positive = 1'b0;
    sext_immed = '0; jump_addr = '0;
    repeat (2) @(posedge clk);
    tick;
    chk("rst_pc", pc, 32'h0);
    chk("rst_post_pc", post_pc, 32'h1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_count", retired_count, 32'h0);
    rst = 1'b0;
    tick;
    chk("first_fetch_req", 32'(imem_req), 32'h1);
    do_fetch(32'h1234_5678, 0);
    chk("zws_instr", instr, 32'h1234_5678);
    chk("zws_valid", 32'(instr_valid), 32'h1);
    chk("zws_post_pc", post_pc, 32'h1);
    do_accept(0);
    do_resolve(1'b1, 1'b0, 1'b0, 32'h0, 26'd10);
    chk("jump_to_10", pc, 32'd10);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 26'h0);
    chk("beq_taken", pc, 32'd8);
    chk("model_beq_taken", m_pc, 32'd8);
    step(1'b1, 1'b0, 1'b0, 32'h0, 26'd10);
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD, 26'h0);
    chk("beq_not_taken", pc, 32'd11);
    step(1'b0, 1'b1, 1'b1, 32'h03FF_FFF8, 26'h0);
    chk("far_branch_pc", pc, 32'h0400_0004);
    chk("far_branch_post", post_pc, 32'h0400_0005);
    step(1'b1, 1'b1, 1'b1, 32'h5, 26'h000_0100);
    chk("jump_priority", pc, 32'h0400_0100);
    chk("model_jump", m_pc, 32'h0400_0100);
    wait_ph(1);
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 32'(imem_req), 32'h1);
      chk("wait_addr", imem_addr, 32'h0400_0100);
      tick;
    end
    chk("wait_req4", 32'(imem_req), 32'h1);
    chk("wait_addr4", imem_addr, 32'h0400_0100);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick;
    imem_ack = 1'b0; imem_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_instr", instr, 32'hCAFE_F00D);
      tick;
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    chk("accepted_valid", 32'(instr_valid), 32'h0);
    chk("accepted_instr", instr, 32'hCAFE_F00D);
    do_resolve(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("retired_7", retired_count, 32'd7);
    wait_ph(1);
    rst = 1'b1;
    tick;
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 1'b0;
    chk("late_ack_req", 32'(imem_req), 32'h1);
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", 32'(instr_valid), 32'h0);
    chk("late_ack_count", retired_count, 32'h0);
    do_fetch(32'h0000_0042, 1);
    wait_ph(2);
    force dut.r_retired = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    resolve_valid = 1'b1;
    tick;
    resolve_valid = 1'b0;
    chk("stray_resolve_cnt", retired_count, 32'hFFFF_FFFF);
    chk("stray_resolve_hold", 32'(instr_valid), 32'h1);
    do_accept(0);
    do_resolve(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("count_wrap", retired_count, 32'h0);
    chk("model_wrap", m_cnt, 32'h0);
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 255) == 0);
      imem_ack      = ($urandom_range(0, 4) < 2);
      imem_rdata    = $urandom;
      instr_ready   = $urandom_range(0, 1) == 1;
      resolve_valid = ($urandom_range(0, 4) < 2);
      branch        = $urandom_range(0, 1) == 1;
      branch_ne     = $urandom_range(0, 1) == 1;
      branch_gz     = $urandom_range(0, 1) == 1;
      jump          = ($urandom_range(0, 3) == 0);
      alu_zero      = $urandom_range(0, 1) == 1;
      alu_positive  = $urandom_range(0, 1) == 1;
      sext_immed    = $urandom_range(0, 1) == 1 ? $urandom
                    : 32'($signed($urandom_range(0, 64)) - 32);
      jump_addr     = 26'($urandom);
      tick;
    end
    rst = 1'b0; imem_ack = 1'b0; resolve_valid = 1'b0; instr_ready = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
